// File: rtl/pipirima_defs.sv
// Shared definitions for the IMU-side blocks: lane geometry, FSM encodings
// and a lane-slice helper for packed multi-lane words.
`ifndef PIPIRIMA_DEFS_SV
`define PIPIRIMA_DEFS_SV

`define CBB_LANE(idx, width) ((idx)*(width)) +: (width)

package pipirima_defs;

    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

`endif

// File: rtl/cbb_result_fifo.sv
// Two-entry result buffer with a registered head word. A push that arrives
// while full and without a simultaneous pop is refused and flagged on o_drop.
module cbb_result_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_drop
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_drop  = i_push && (r_count == 2'd2) && !w_pop;
    assign o_data  = r_head;
    assign o_empty = (r_count == 2'd0);

    // Head always holds the oldest entry so the output needs no read mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cbb_accumulator.sv
// Lane-wise accumulator behind the IMU: sums a programmable number of valid
// beats per lane and hands each completed group to a 2-entry result buffer.
module cbb_accumulator #(
    parameter int LANES = pipirima_defs::LANES,
    parameter int DW    = pipirima_defs::DW,
    parameter int CNT_W = pipirima_defs::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                in_valid,
    input  logic [CNT_W-1:0]    beats,
    output logic [LANES*DW-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                overflow
);

    import pipirima_defs::state_t;
    import pipirima_defs::IDLE;
    import pipirima_defs::ACCUM;

    state_t              r_state;
    state_t              w_nextState;
    logic [DW-1:0]       r_acc [LANES];
    logic [DW-1:0]       w_sum [LANES];
    logic [LANES*DW-1:0] w_sumFlat;
    logic [LANES*DW-1:0] w_pushData;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_target;
    logic [CNT_W-1:0]    w_beatsEff;
    logic [CNT_W-1:0]    w_cntNext;
    logic                w_push;
    logic                w_drop;
    logic                w_empty;
    logic                r_overflow;

    assign w_beatsEff = (beats == '0) ? CNT_W'(1) : beats;
    assign w_cntNext  = r_cnt + CNT_W'(1);

    // Each lane wraps on its own; no carry is shared between lanes.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_sum[g] = r_acc[g] + in_data[`CBB_LANE(g, DW)];
        assign w_sumFlat[`CBB_LANE(g, DW)] = w_sum[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        w_pushData  = in_data;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_beatsEff == CNT_W'(1)) begin
                        w_push = 1'b1;
                    end else begin
                        w_nextState = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid && (w_cntNext == r_target)) begin
                    w_push      = 1'b1;
                    w_pushData  = w_sumFlat;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Group length is latched on the first beat so later beats changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_target <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (in_valid) begin
            if (r_state == IDLE) begin
                r_cnt    <= CNT_W'(1);
                r_target <= w_beatsEff;
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= in_data[`CBB_LANE(i, DW)];
                end
            end else begin
                r_cnt <= w_cntNext;
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= w_sum[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    cbb_result_fifo #(
        .W (LANES*DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign out_valid = !w_empty;
    assign busy      = (r_state == ACCUM);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cbb_accumulator.sv
// Scoreboard bench for cbb_accumulator: expected results are queued as each
// group completes and a negedge monitor checks every accepted output word.
module tb_cbb_accumulator;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic [7:0]   beats;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overflow;

    int compared   = 0;
    int mismatched = 0;
    logic [127:0] expQ [$];

    cbb_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .beats     (beats),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pack4(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One accepted beat: sampled on the next rising edge, outputs readable 1 unit later.
    task automatic applyStimulus(input logic [127:0] d, input logic [7:0] b);
        in_data  = d;
        beats    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got %h, expected no result", out_data);
            end else begin
                checkOutput("result", out_data, expQ.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        beats     = 8'd1;
        out_ready = 1'b0;
        idleCycles(2);
        checkOutput("reset_out_data",  out_data, 128'd0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy",      128'(busy), 128'd0);
        checkOutput("reset_overflow",  128'(overflow), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(1);

        // Four-beat group.
        out_ready = 1'b1;
        expQ.push_back(pack4(60, 40, 20, 0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(pack4(15, 10, 5, 0), 8'd4);
            if (k == 0) checkOutput("t1_busy_mid", 128'(busy), 128'd1);
        end
        checkOutput("t1_out_valid", 128'(out_valid), 128'd1);
        checkOutput("t1_busy_after", 128'(busy), 128'd0);
        idleCycles(1);
        checkOutput("t1_drained", 128'(out_valid), 128'd0);

        // Single-beat groups back to back.
        for (int v = 1; v <= 5; v++) begin
            expQ.push_back(pack4(0, 0, 0, v));
            applyStimulus(pack4(0, 0, 0, v), 8'd1);
            checkOutput("t2_out_valid", 128'(out_valid), 128'd1);
        end
        idleCycles(1);
        checkOutput("t2_overflow", 128'(overflow), 128'd0);
        checkOutput("t2_drained", 128'(out_valid), 128'd0);

        // Full buffer drops the third result.
        out_ready = 1'b0;
        expQ.push_back(pack4(3, 2, 1, 32'h11));
        expQ.push_back(pack4(3, 2, 1, 32'h22));
        applyStimulus(pack4(3, 2, 1, 32'h11), 8'd1);
        checkOutput("t3_overflow_early", 128'(overflow), 128'd0);
        applyStimulus(pack4(3, 2, 1, 32'h22), 8'd1);
        applyStimulus(pack4(3, 2, 1, 32'h33), 8'd1);
        checkOutput("t3_overflow", 128'(overflow), 128'd1);
        checkOutput("t3_head_held", out_data, pack4(3, 2, 1, 32'h11));
        out_ready = 1'b1;
        idleCycles(3);
        checkOutput("t3_drained", 128'(out_valid), 128'd0);
        checkOutput("t3_overflow_sticky", 128'(overflow), 128'd1);

        // Lane wrap without carry into neighbours.
        expQ.push_back(pack4(1, 15, 0, 2));
        applyStimulus(pack4(32'hFFFF_FFFF, 7, 0, 1), 8'd2);
        applyStimulus(pack4(2, 8, 0, 1), 8'd2);
        idleCycles(1);

        // Reset mid-group discards the partial sum.
        applyStimulus(pack4(100, 100, 100, 100), 8'd3);
        applyStimulus(pack4(100, 100, 100, 100), 8'd3);
        checkOutput("t5_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_out_data",  out_data, 128'd0);
        checkOutput("t5_rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("t5_rst_busy",      128'(busy), 128'd0);
        checkOutput("t5_rst_overflow",  128'(overflow), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(1);
        expQ.push_back(pack4(3, 3, 3, 6));
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(pack4(1, 1, 1, k), 8'd3);
        end
        idleCycles(1);

        // beats = 0 acts as 1; mid-group beats change is ignored.
        expQ.push_back(pack4(0, 0, 0, 9));
        applyStimulus(pack4(0, 0, 0, 9), 8'd0);
        checkOutput("t6_zero_busy", 128'(busy), 128'd0);
        idleCycles(1);
        expQ.push_back(pack4(0, 0, 0, 7));
        applyStimulus(pack4(0, 0, 0, 1), 8'd3);
        applyStimulus(pack4(0, 0, 0, 2), 8'd2);
        checkOutput("t6_busy_after_2", 128'(busy), 128'd1);
        applyStimulus(pack4(0, 0, 0, 4), 8'd2);
        checkOutput("t6_busy_after_3", 128'(busy), 128'd0);
        checkOutput("t6_out_valid", 128'(out_valid), 128'd1);
        idleCycles(3);

        checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cbb_accumulator.md
# cbb_accumulator

Lane-wise accumulator that sits directly downstream of the IMU and consumes its 128-bit `data` / `CBB_valid` output stream. It sums a programmable number of consecutive valid beats per lane into one result word. It then queues the completed result in a 2-entry output buffer and presents it to the next stage over a valid/ready handshake. The IMU has no backpressure input, so this block accepts every input beat unconditionally and flags any result it has to drop.

## Interface
- `LANES`, 4, number of 32-bit lanes in an IMU output word
- `DW`, 32, lane width in bits
- `CNT_W`, 8, width of the beat-count field
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  LANES*DW  IMU output; lane i = `in_data[i*DW +: DW]`
- `in_valid`  in  1  IMU `CBB_valid`; beat accepted on every edge where high
- `beats`  in  CNT_W  beats per group; sampled only on the first beat of a group
- `out_data`  out  LANES*DW  head-of-buffer result, lane-wise sums
- `out_valid`  out  1  buffer non-empty
- `out_ready`  in  1  downstream accepts `out_data` when high together with `out_valid`
- `busy`  out  1  group in progress (state ACCUM)
- `overflow`  out  1  sticky; set when a completed result is dropped

## Operation
- FSM states:
  - IDLE:
    - `in_valid` → `acc` = `in_data` lanes, `cnt` = 1, `target` = `beats`; `beats` = 0 is treated as 1.
    - If `target` = 1, push `in_data` to the buffer and stay in IDLE; else go to ACCUM.
  - ACCUM:
    - `in_valid` → `cnt` = `cnt` + 1.
    - If `cnt` + 1 = `target`, push `acc` + `in_data` and go to IDLE; else `acc` += `in_data`.
    - `in_valid` low → hold all state, with no timeout.
- Arithmetic: per-lane unsigned addition modulo 2^DW; carries never cross lanes; no saturation.
- Output buffer, depth 2:
  - Push on group completion; pop on `out_valid && out_ready`.
  - Push while full and no pop in the same cycle → result dropped, `overflow` set, buffer contents unchanged.
  - Push and pop in the same cycle while full → both succeed, no overflow.
  - Pop while empty is ignored.
- `beats` changes mid-group have no effect until the next group starts.
- Reset, including mid-group: asynchronously returns to IDLE, clears `acc`, `cnt`, `target` and the buffer, and clears `overflow`. The partial group is discarded.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `busy` = 0, `overflow` = 0.
- Latency: the final beat of a group is sampled at edge N; `out_valid` is high and `out_data` valid after edge N (registered buffer, no combinational path from `in_*` to `out_*`).
- `out_data` is stable while `out_valid && !out_ready`.
- `overflow` rises after the edge that dropped the result.
- Throughput: one input beat per cycle sustained. With `beats` = 1 and `out_ready` held high, one result is produced per cycle with no drops.
- `out_ready` has no combinational path to any input-side logic.

## Structure
- Shared package / include `pipirima_defs`: `DW` = 32, `LANES` = 4, FSM state encodings (IDLE = 0, ACCUM = 1), lane-slice helper macro.
- Sub-module `cbb_result_fifo`: 2-entry synchronous FIFO with registered output. It reports full/empty; push-when-full without pop is refused and signalled to the parent, which drives `overflow`.
- The top level holds the FSM, the counters and the lane adders (LANES instances in a generate loop).

## Test plan
- `beats` = 4, `out_ready` = 1, four beats each with lanes {0, 5, 10, 15} → one `out_data` of lanes {0, 20, 40, 60}, `out_valid` high after the 4th beat's edge, `busy` low afterwards.
- `beats` = 1, 5 consecutive beats with lane0 = 1..5, `out_ready` = 1 → five results with lane0 = 1..5 on consecutive cycles, `overflow` = 0.
- `beats` = 1, `out_ready` = 0, three beats → buffer holds beats 1 and 2, the third is dropped, `overflow` = 1. Raising `out_ready` drains 1 then 2.
- `beats` = 2, lane3 = 0xFFFF_FFFF then 2 → lane3 = 1 (wrap), other lanes unaffected by the carry.
- `beats` = 3, two beats then `rst` pulsed mid-group → all outputs return to reset values immediately. The next 3-beat group sums only post-reset beats.
- `beats` = 0 → behaves as 1. `beats` changed 3→2 after the first beat of a group → the group still completes after 3 beats.
